uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 57 +++++
 rtl/uart_rx_fifo.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, parity mode
// constants, character width and the parity check helper.
package uart_pkg;

  localparam int DATA_W = 8;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // True when the received parity bit is consistent with the data byte.
  function automatic logic parity_good(input logic [DATA_W-1:0] d,
                                       input logic p, input int mode);
    logic x;
    x = ^{d, p};
    case (mode)
      PAR_EVEN: parity_good = (x == 1'b0);
      PAR_ODD:  parity_good = (x == 1'b1);
      default:  parity_good = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO, 2**DEPTH_LOG2 entries.
// Ports:
//   clk      clock, all state on rising edge
//   rst      asynchronous active-low reset (pointers only)
//   wr_en    push request; dropped when full unless a pop happens too
//   wr_data  byte to push
//   rd_en    pop request; ignored when empty
//   rd_data  head entry, forced to zero while empty
//   empty    no entries held
//   full     all entries held
module sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when indices match.
  logic [DEPTH_LOG2:0] wptr, rptr;
  logic do_wr, do_rd;

  assign empty = (wptr == rptr);
  assign full  = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                 (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a
  // simultaneous push; an empty FIFO has nothing to pop even if a push lands.
  assign do_wr = wr_en && (!full || rd_en);
  assign do_rd = rd_en && !empty;

  assign rd_data = empty ? '0 : mem[rptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[DEPTH_LOG2-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8 data bits, optional parity, 1 stop) feeding a byte FIFO.
// Ports:
//   clk         clock, all state on rising edge
//   rst         asynchronous active-low reset
//   rx          serial line, idle high, asynchronous to clk
//   rd_en       pop the FIFO head
//   clr_err     clear the sticky error flags
//   rd_data     FIFO head byte (first-word-fall-through, 0 when empty)
//   empty/full  FIFO status
//   overflow    sticky: good byte dropped because the FIFO was full
//   parity_err  sticky: frame dropped for parity mismatch
//   frame_err   sticky: frame dropped for a low stop bit
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 1,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              parity_err,
  output logic              frame_err
);

  localparam logic [15:0] BIT_CNT  = 16'(CLKS_PER_BIT);
  localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2);

  logic rx_p0, rx_p1, rx_p2;
  logic fall;

  rx_state_t         state, state_nxt;
  logic [15:0]       cnt, cnt_nxt;
  logic [2:0]        bit_idx, bit_nxt;
  logic [DATA_W-1:0] shift, shift_nxt;
  logic              par_bit, par_nxt;
  logic              tick;
  logic              push_nxt, set_fe, set_pe, set_ovf;
  logic              push_p0;

  // Stage p0/p1: two-flop synchronizer; p2 holds the previous synced level
  // so a start is recognised only on a genuine high-to-low transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  assign fall = rx_p2 && !rx_p1;

  // The counter expires at 1, giving exactly CLKS_PER_BIT cycles per reload.
  assign tick = (cnt == 16'd1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    par_nxt   = par_bit;
    push_nxt  = 1'b0;
    set_fe    = 1'b0;
    set_pe    = 1'b0;
    if (state != ST_IDLE) cnt_nxt = tick ? BIT_CNT : cnt - 16'd1;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (fall) begin
          state_nxt = ST_START;
          cnt_nxt   = HALF_CNT;
        end
      end
      ST_START: if (tick) begin
        if (rx_p1) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          state_nxt = ST_DATA;
          bit_nxt   = '0;
        end
      end
      ST_DATA: if (tick) begin
        shift_nxt = {rx_p1, shift[DATA_W-1:1]};
        bit_nxt   = bit_idx + 3'd1;
        if (bit_idx == 3'd7) state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (tick) begin
        par_nxt   = rx_p1;
        state_nxt = ST_STOP;
      end
      ST_STOP: if (tick) begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        if (!rx_p1)                                 set_fe   = 1'b1;
        else if (!parity_good(shift, par_bit, PARITY)) set_pe = 1'b1;
        else                                        push_nxt = 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      push_p0 <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      push_p0 <= push_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shift   <= shift_nxt;
    par_bit <= par_nxt;
  end

  // Stage p0 -> FIFO: the accepted byte is written the cycle after the stop
  // sample; the shift register is idle by then, so it still holds the byte.
  assign set_ovf = push_p0 && full && !rd_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (set_ovf)      overflow   <= 1'b1;
      else if (clr_err) overflow   <= 1'b0;
      if (set_pe)       parity_err <= 1'b1;
      else if (clr_err) parity_err <= 1'b0;
      if (set_fe)       frame_err  <= 1'b1;
      else if (clr_err) frame_err  <= 1'b0;
    end
  end

  sync_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (push_p0),
    .wr_data(shift),
    .rd_en  (rd_en),
    .rd_data(rd_data),
    .empty  (empty),
    .full   (full)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       empty, full, overflow, parity_err, frame_err;

  int n_chk;
  int n_err;

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .PARITY      (1),
    .DEPTH_LOG2  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
    put_bit(1'b0);
    for (int i = 0; i < 8; i++) put_bit(b[i]);
    put_bit(p);
    put_bit(s);
    rx = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  task automatic pop;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic clear;
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_flags(input string tag, input logic ov, input logic pe, input logic fe);
    check({tag, "_ovf"}, overflow, ov);
    check({tag, "_perr"}, parity_err, pe);
    check({tag, "_ferr"}, frame_err, fe);
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    rst     = 1'b0;
    rx      = 1'b1;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // A5: four ones, even parity bit 0
    send_frame(8'hA5, 1'b0, 1'b1);
    check("a5_empty", empty, 1'b0);
    check("a5_data", rd_data, 8'hA5);
    check_flags("a5", 1'b0, 1'b0, 1'b0);
    pop();
    check("a5_pop_empty", empty, 1'b1);
    check("a5_pop_data", rd_data, 8'h00);

    // 3C: four ones, wrong parity bit 1
    send_frame(8'h3C, 1'b1, 1'b1);
    check("3c_perr", parity_err, 1'b1);
    check("3c_empty", empty, 1'b1);
    check("3c_ferr", frame_err, 1'b0);
    clear();
    check("3c_clr_perr", parity_err, 1'b0);

    // 55: correct parity, stop bit low
    send_frame(8'h55, 1'b0, 1'b0);
    check("55_ferr", frame_err, 1'b1);
    check("55_perr", parity_err, 1'b0);
    check("55_empty", empty, 1'b1);
    clear();
    check("55_clr_ferr", frame_err, 1'b0);

    // Fill the 4-entry FIFO, then overflow on the fifth byte
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'h02, 1'b1, 1'b1);
    send_frame(8'h03, 1'b0, 1'b1);
    check("fill3_full", full, 1'b0);
    send_frame(8'h04, 1'b1, 1'b1);
    check("fill4_full", full, 1'b1);
    check("fill4_ovf", overflow, 1'b0);
    send_frame(8'h05, 1'b0, 1'b1);
    check("fill5_ovf", overflow, 1'b1);
    check("fill5_full", full, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("read%0d", i), rd_data, 32'(i));
      pop();
    end
    check("drain_empty", empty, 1'b1);
    check("drain_full", full, 1'b0);
    clear();
    check("drain_clr_ovf", overflow, 1'b0);

    // Short low glitch: false start, no flags, nothing stored
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_empty", empty, 1'b1);
    check_flags("glitch", 1'b0, 1'b0, 1'b0);

    // Reset during data bit 3 of FF, then a clean 12
    put_bit(1'b0);
    for (int i = 0; i < 3; i++) put_bit(1'b1);
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_empty", empty, 1'b1);
    check("midrst_rd_data", rd_data, 8'h00);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("postrst_empty", empty, 1'b1);
    send_frame(8'h12, 1'b0, 1'b1);
    check("12_data", rd_data, 8'h12);
    check_flags("12", 1'b0, 1'b0, 1'b0);
    pop();
    check("12_pop_empty", empty, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
